// File: rtl/decred_result_collector_pkg.sv
// Shared constants and FSM state type for the result collector and its FIFO.
package decred_result_collector_pkg;

  localparam int unsigned     DEFAULT_NUMBER_OF_MACROS = 4;
  localparam logic [5:0]      DEFAULT_RESULT_BASE_ADDR = 6'h38;
  localparam logic [3:0]      HEADER_NIBBLE            = 4'hD;
  localparam logic [7:0]      STALL_LAST_CYCLE         = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    READ,
    DRAIN
  } collector_state_e;

endpackage

// File: rtl/decred_result_collector_fifo.sv
// Byte FIFO with record checkpoint/commit/rewind; only committed bytes are visible to the consumer.
module decred_result_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [7:0]                   push_data,
  input  logic                         push_last,
  input  logic                         pop,
  input  logic                         checkpoint,
  input  logic                         rewind,
  input  logic                         commit,
  output logic [7:0]                   head_data,
  output logic                         head_last,
  output logic                         head_valid,
  output logic [$clog2(DEPTH+1)-1:0]   free_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [8:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, ckpt_ptr;
  logic [CW-1:0] count, pend_cnt;
  logic [CW-1:0] visible;
  logic          do_push, do_pop;

  // Entries since the checkpoint are held back from the consumer until commit.
  assign visible    = count - pend_cnt;
  assign head_valid = (visible != '0);
  assign do_pop     = pop && head_valid;
  assign do_push    = push && !rewind && ((count != CW'(DEPTH)) || do_pop);
  assign free_cnt   = CW'(DEPTH) - count;
  assign head_data  = head_valid ? mem[rd_ptr][7:0] : '0;
  assign head_last  = head_valid ? mem[rd_ptr][8]   : 1'b0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_last, push_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ckpt_ptr <= '0;
      count    <= '0;
      pend_cnt <= '0;
    end else begin
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (rewind) begin
        wr_ptr   <= ckpt_ptr;
        count    <= count - pend_cnt - CW'(do_pop);
        pend_cnt <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        count <= count + CW'(do_push) - CW'(do_pop);
        if (checkpoint) begin
          ckpt_ptr <= wr_ptr;
          pend_cnt <= CW'(do_push);
        end else if (commit) begin
          pend_cnt <= '0;
        end else begin
          pend_cnt <= pend_cnt + CW'(do_push);
        end
      end
    end
  end

endmodule

// File: rtl/decred_result_collector.sv
// Round-robin collector: reads result bytes from ready hash macros and queues header+data records.
module decred_result_collector
  import decred_result_collector_pkg::*;
#(
  parameter int unsigned NUMBER_OF_MACROS = DEFAULT_NUMBER_OF_MACROS,
  parameter logic [5:0]  RESULT_BASE_ADDR = DEFAULT_RESULT_BASE_ADDR,
  parameter int unsigned RESULT_BYTES     = 4,
  parameter int unsigned FIFO_DEPTH       = 16
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic [NUMBER_OF_MACROS-1:0] DATA_AVAILABLE,
  output logic                        RD_REQ,
  input  logic                        RD_GNT,
  output logic [NUMBER_OF_MACROS-1:0] MACRO_RD_SELECT,
  output logic [5:0]                  HASH_ADDR,
  input  logic [7:0]                  DATA_FROM_HASH,
  output logic [7:0]                  OUT_DATA,
  output logic                        OUT_LAST,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  output logic                        RESULT_IRQ,
  output logic [7:0]                  OVERFLOW_CNT
);

  localparam int unsigned IW = (NUMBER_OF_MACROS > 1) ? $clog2(NUMBER_OF_MACROS) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  collector_state_e state, state_next;

  logic [IW-1:0]               win_q, rr_q, winner;
  logic                        win_found;
  logic [2:0]                  k_q;
  logic                        cap_valid_q, cap_last_q;
  logic [NUMBER_OF_MACROS-1:0] served_q, pending, served_set;
  logic [7:0]                  stall_q, ovf_q;
  logic                        irq_q;
  logic                        space_ok, drop, rec_done, stalled;
  logic                        push, push_last, checkpoint, rewind, commit;
  logic [7:0]                  push_data;
  logic [CW-1:0]               fifo_free;
  int unsigned                 cand;

  assign pending  = DATA_AVAILABLE & ~served_q;
  assign space_ok = (fifo_free >= CW'(RESULT_BYTES + 1));
  assign stalled  = (state == IDLE) && win_found && !space_ok;
  assign drop     = stalled && (stall_q == STALL_LAST_CYCLE);

  // Search starts one past the last served macro and wraps.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    cand      = 0;
    for (int unsigned i = 1; i <= NUMBER_OF_MACROS; i++) begin
      cand = (32'(rr_q) + i) % NUMBER_OF_MACROS;
      if (!win_found && pending[cand]) begin
        win_found = 1'b1;
        winner    = IW'(cand);
      end
    end
  end

  always_comb begin
    state_next      = state;
    RD_REQ          = 1'b0;
    MACRO_RD_SELECT = '0;
    HASH_ADDR       = '0;
    push            = 1'b0;
    push_data       = '0;
    push_last       = 1'b0;
    checkpoint      = 1'b0;
    rewind          = 1'b0;
    commit          = 1'b0;
    rec_done        = 1'b0;
    served_set      = '0;
    case (state)
      IDLE: begin
        if (win_found && space_ok) state_next = REQ;
        if (drop) served_set = NUMBER_OF_MACROS'(1) << winner;
      end
      REQ: begin
        RD_REQ = 1'b1;
        if (RD_GNT) begin
          push       = 1'b1;
          push_data  = {HEADER_NIBBLE, 4'(win_q)};
          checkpoint = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        RD_REQ          = 1'b1;
        MACRO_RD_SELECT = NUMBER_OF_MACROS'(1) << win_q;
        HASH_ADDR       = RESULT_BASE_ADDR + 6'(k_q);
        if (!RD_GNT) begin
          rewind     = 1'b1;
          state_next = IDLE;
        end else begin
          push      = cap_valid_q;
          push_data = DATA_FROM_HASH;
          push_last = cap_last_q;
          if (k_q == 3'(RESULT_BYTES - 1)) state_next = DRAIN;
        end
      end
      DRAIN: begin
        RD_REQ = 1'b1;
        if (!RD_GNT) begin
          rewind     = 1'b1;
          state_next = IDLE;
        end else begin
          push       = cap_valid_q;
          push_data  = DATA_FROM_HASH;
          push_last  = cap_last_q;
          commit     = 1'b1;
          rec_done   = 1'b1;
          served_set = NUMBER_OF_MACROS'(1) << win_q;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      win_q       <= '0;
      rr_q        <= IW'(NUMBER_OF_MACROS - 1);
      k_q         <= '0;
      cap_valid_q <= 1'b0;
      cap_last_q  <= 1'b0;
      served_q    <= '0;
      stall_q     <= '0;
      ovf_q       <= '0;
      irq_q       <= 1'b0;
    end else begin
      state       <= state_next;
      irq_q       <= OUT_VALID;
      served_q    <= (served_q | served_set) & DATA_AVAILABLE;
      cap_valid_q <= (state == READ) && RD_GNT;
      cap_last_q  <= (k_q == 3'(RESULT_BYTES - 1));
      if ((state == IDLE) && (state_next == REQ)) win_q <= winner;
      if (state == REQ)       k_q <= '0;
      else if (state == READ) k_q <= k_q + 1'b1;
      if (stalled) stall_q <= drop ? '0 : stall_q + 1'b1;
      else         stall_q <= '0;
      if (rec_done)  rr_q <= win_q;
      else if (drop) rr_q <= winner;
      if (drop && (ovf_q != 8'hFF)) ovf_q <= ovf_q + 1'b1;
    end
  end

  assign RESULT_IRQ   = irq_q;
  assign OVERFLOW_CNT = ovf_q;

  decred_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .push       (push),
    .push_data  (push_data),
    .push_last  (push_last),
    .pop        (OUT_READY),
    .checkpoint (checkpoint),
    .rewind     (rewind),
    .commit     (commit),
    .head_data  (OUT_DATA),
    .head_last  (OUT_LAST),
    .head_valid (OUT_VALID),
    .free_cnt   (fifo_free)
  );

endmodule
